// File: rtl/jam_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jam_rr_arbiter
// Brief    : Jam-mode grant arbiter; one-hot road grant with fixed-priority
//            start, round-robin rotation and minimum green dwell.
//            Optional JAM_AUTO_ROTATE_EN: auto-rotate away from a cleared road.
// Revision : 1.0 - initial release
// ============================================================================
module jam_rr_arbiter #(
    parameter int NUM_ROADS = 4,
    parameter int MIN_GREEN = 8,
    parameter int IDX_W     = $clog2(NUM_ROADS),
    parameter int CNT_W     = $clog2(MIN_GREEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_ROADS-1:0] i_jam_sensor,
    input  logic                 i_jam_op_en,
    input  logic                 i_jam_start,
    input  logic                 i_jam_rotation,
    output logic [NUM_ROADS-1:0] o_allow_jam,
    output logic [IDX_W-1:0]     o_current_road,
    output logic                 o_busy,
    output logic                 o_dwell_done,
    output logic                 o_grant_pulse
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GREEN = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_DWELL_LOAD = CNT_W'(MIN_GREEN - 1);
    localparam state_t           c_GRANT_ST   = (MIN_GREEN == 1) ? S_READY : S_GREEN;

    state_t                 r_state;
    logic [NUM_ROADS-1:0]   r_allow;
    logic [IDX_W-1:0]       r_road;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pend;
    logic                   r_pulse;

    logic                   w_any;
    logic [IDX_W-1:0]       w_low_idx;
    logic                   w_rot_found;
    logic [IDX_W-1:0]       w_rot_idx;
    logic                   w_auto;
    logic                   w_start_grant;
    logic                   w_rot_exec;
    logic [IDX_W-1:0]       w_grant_idx;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int k);
        return IDX_W'((int'(base) + k) % NUM_ROADS);
    endfunction

    assign w_any = |i_jam_sensor;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_ROADS - 1; i >= 0; i--) begin
            if (i_jam_sensor[i]) w_low_idx = IDX_W'(i);
        end
    end

    // Descending offset so the nearest road after current_road wins; offset
    // NUM_ROADS lands on current_road itself, which is therefore checked last.
    always_comb begin
        w_rot_found = 1'b0;
        w_rot_idx   = r_road;
        for (int k = NUM_ROADS; k >= 1; k--) begin
            if (i_jam_sensor[wrap_idx(r_road, k)]) begin
                w_rot_found = 1'b1;
                w_rot_idx   = wrap_idx(r_road, k);
            end
        end
    end

`ifdef JAM_AUTO_ROTATE_EN
    assign w_auto = (r_state == S_READY) && !i_jam_sensor[r_road];
`else
    assign w_auto = 1'b0;
`endif

    // A start request owns the edge even when no sensor is set, so rotation is dropped.
    assign w_start_grant = i_jam_start && w_any;
    assign w_rot_exec    = !i_jam_start && (r_state != S_GREEN) &&
                           (i_jam_rotation || r_pend || w_auto);
    assign w_grant_idx   = w_start_grant ? w_low_idx : w_rot_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_allow <= '0;
            r_road  <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_pulse <= 1'b0;
        end else if (!i_jam_op_en) begin
            r_state <= S_IDLE;
            r_allow <= '0;
            r_road  <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_start_grant || (w_rot_exec && w_rot_found)) begin
                r_state            <= c_GRANT_ST;
                r_allow            <= '0;
                r_allow[w_grant_idx] <= 1'b1;
                r_road             <= w_grant_idx;
                r_cnt              <= c_DWELL_LOAD;
                r_pend             <= 1'b0;
                r_pulse            <= 1'b1;
            end else if (w_rot_exec) begin
                r_state <= S_IDLE;
                r_allow <= '0;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
            end else if (r_state == S_GREEN) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) r_state <= S_READY;
                if (i_jam_rotation && !i_jam_start) r_pend <= 1'b1;
            end
        end
    end

    assign o_allow_jam    = r_allow;
    assign o_current_road = r_road;
    assign o_busy         = (r_state != S_IDLE);
    assign o_dwell_done   = (r_state == S_READY);
    assign o_grant_pulse  = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_jam_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jam_rr_arbiter
// Brief    : Self-checking bench for jam_rr_arbiter: cycle model plus directed
//            literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jam_rr_arbiter;

    localparam int N  = 4;
    localparam int MG = 8;
`ifdef JAM_AUTO_ROTATE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] sensor = '0;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         rot = 1'b0;
    logic [N-1:0] allow;
    logic [1:0]   road;
    logic         busy;
    logic         dwell_done;
    logic         pulse;

    int checks = 0;
    int errors = 0;

    jam_rr_arbiter #(.NUM_ROADS(N), .MIN_GREEN(MG)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_jam_sensor   (sensor),
        .i_jam_op_en    (en),
        .i_jam_start    (start),
        .i_jam_rotation (rot),
        .o_allow_jam    (allow),
        .o_current_road (road),
        .o_busy         (busy),
        .o_dwell_done   (dwell_done),
        .o_grant_pulse  (pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model: a grant is (road, age since grant); ready once age >= MG-1.
    bit m_active;
    int m_road;
    int m_age;
    bit m_pend;
    bit m_pulse;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !en) begin
            m_active <= 1'b0; m_road <= 0; m_age <= 0; m_pend <= 1'b0; m_pulse <= 1'b0;
        end else begin : model_step
            bit ready;
            bit want;
            int pick;
            ready = m_active && (m_age >= MG - 1);
            m_pulse <= 1'b0;
            if (start && sensor != 0) begin
                pick = -1;
                for (int i = N - 1; i >= 0; i--) if (sensor[i]) pick = i;
                m_active <= 1'b1; m_road <= pick; m_age <= 0; m_pulse <= 1'b1; m_pend <= 1'b0;
            end else if (m_active && !ready) begin
                m_age <= m_age + 1;
                if (rot && !start) m_pend <= 1'b1;
            end else if (!start) begin
                want = rot || m_pend || (AUTO && ready && !sensor[m_road]);
                if (want) begin
                    pick = -1;
                    for (int k = N; k >= 1; k--) if (sensor[(m_road + k) % N]) pick = (m_road + k) % N;
                    m_pend <= 1'b0;
                    if (pick >= 0) begin
                        m_active <= 1'b1; m_road <= pick; m_age <= 0; m_pulse <= 1'b1;
                    end else begin
                        m_active <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_allow", int'(allow), m_active ? (1 << m_road) : 0);
        chk("model_road", int'(road), m_road);
        chk("model_busy", int'(busy), int'(m_active));
        chk("model_dwell", int'(dwell_done), int'(m_active && m_age >= MG - 1));
        chk("model_pulse", int'(pulse), int'(m_pulse));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start(input logic [N-1:0] s);
        sensor = s; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        en = 1'b0; sensor = 4'b1111;
        cyc(3);
        chk("reset_allow", int'(allow), 0);
        rst_n = 1'b1;
        cyc(3);
        chk("dis_allow", int'(allow), 0);
        chk("dis_road", int'(road), 0);
        chk("dis_busy", int'(busy), 0);

        // Fixed-priority start
        en = 1'b1;
        do_start(4'b1010);
        chk("start_allow", int'(allow), 4'b0010);
        chk("start_road", int'(road), 1);
        chk("start_pulse", int'(pulse), 1);
        cyc(1);
        chk("start_pulse_end", int'(pulse), 0);
        cyc(5);
        chk("dwell_not_yet", int'(dwell_done), 0);
        cyc(1);
        chk("dwell_done", int'(dwell_done), 1);

        // Pended rotation with wrap
        do_start(4'b1000);
        sensor = 4'b1001;
        cyc(1);
        rot = 1'b1;
        cyc(1);
        rot = 1'b0;
        cyc(5);
        chk("pend_hold", int'(allow), 4'b1000);
        cyc(1);
        chk("pend_wrap_allow", int'(allow), 4'b0001);
        chk("pend_wrap_pulse", int'(pulse), 1);

        // Re-grant and release
        do_start(4'b0100);
        cyc(7);
        rot = 1'b1;
        cyc(1);
        rot = 1'b0;
        chk("regrant_road", int'(road), 2);
        chk("regrant_pulse", int'(pulse), 1);
        chk("regrant_dwell", int'(dwell_done), 0);
        cyc(7);
        sensor = 4'b0000; rot = 1'b1;
        cyc(1);
        rot = 1'b0;
        chk("release_allow", int'(allow), 0);
        chk("release_busy", int'(busy), 0);
        chk("release_road", int'(road), 2);

        // Start vs rotation collision
        do_start(4'b0001);
        cyc(7);
        sensor = 4'b0110; start = 1'b1; rot = 1'b1;
        cyc(1);
        start = 1'b0; rot = 1'b0;
        chk("coll_road", int'(road), 1);
        for (int i = 0; i < 8; i++) begin
            chk("coll_hold", int'(allow), 4'b0010);
            cyc(1);
        end

        // Auto-rotate on cleared granted road
        do_start(4'b0101);
        cyc(7);
        sensor = 4'b0100;
        cyc(1);
        chk("auto_allow", int'(allow), AUTO ? 4'b0100 : 4'b0001);

        // Disable mid-grant and async reset mid-dwell
        do_start(4'b0010);
        cyc(2);
        en = 1'b0;
        cyc(1);
        chk("disable_allow", int'(allow), 0);
        en = 1'b1;
        do_start(4'b1000);
        cyc(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_allow", int'(allow), 0);
        chk("async_busy", int'(busy), 0);
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        chk("post_rst_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jam_rr_arbiter.md
# jam_rr_arbiter

Parametrised jam-mode grant arbiter for an N-road junction. When the controller enables jam operation, the block grants one jammed road at a time and rotates the grant round-robin among roads whose jam sensors are asserted. Each grant is held for a guaranteed minimum green dwell before a rotation request takes effect. It sits between the road jam sensors and the light sequencer, whose one-hot allow mask it drives.

## Interface
- NUM_ROADS, 4, number of roads/sensors (≥2)
- MIN_GREEN, 8, minimum cycles a grant is held before rotation is honoured (≥1)
- IDX_W, $clog2(NUM_ROADS), width of road index (derived, not overridden)
- CNT_W, $clog2(MIN_GREEN+1), dwell counter width (derived)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- jam_sensor  in  NUM_ROADS  per-road jam flag, bit i = road i
- jam_op_en  in  1  jam mode enable; low = synchronous clear
- jam_start  in  1  fixed-priority (re)grant request
- jam_rotation  in  1  round-robin rotation request
- allow_jam  out  NUM_ROADS  one-hot grant mask, all-zero when idle
- current_road  out  IDX_W  index of last granted road
- busy  out  1  a grant is active (state != IDLE)
- dwell_done  out  1  minimum dwell elapsed (state == READY)
- grant_pulse  out  1  one-cycle strobe on every new grant, including a re-grant

## Operation
- States: IDLE (no grant), GREEN (dwell counter > 0), READY (dwell done).
- Reset or jam_op_en=0 forces: allow_jam=0, current_road=0, state=IDLE, dwell counter=0, rotate_pending=0, grant_pulse=0. jam_op_en=0 overrides jam_start and jam_rotation.
- Priority per edge: disable > jam_start > rotation.
- jam_start, any state:
  - Grants the lowest-index asserted sensor and clears rotate_pending.
  - No sensor asserted: no change to any state or output.
- Rotation search starts at current_road+1, wraps modulo NUM_ROADS, and checks current_road last.
  - The first asserted sensor is granted.
  - Result is current_road: re-grant the same road (dwell reloads, grant_pulse fires).
  - No sensor asserted: go to IDLE, allow_jam=0, current_road unchanged.
- A rotation executes when (jam_rotation or rotate_pending) and the state is READY or IDLE. It clears rotate_pending.
- jam_rotation sampled in GREEN sets rotate_pending; it is not lost. Multiple requests during one dwell collapse into a single rotation.
- Any grant:
  - Sets allow_jam to one-hot(road) and current_road=road.
  - Loads the dwell counter with MIN_GREEN-1.
  - Next state is GREEN, or READY if MIN_GREEN==1.
- In GREEN the counter decrements each cycle; at value 1 the next state is READY (counter reaches 0).
- Sensor changes on the granted road do not revoke a grant; only start, rotation, or disable change it (but see Configuration).

## Timing
- All outputs are registered and respond one edge after inputs are sampled. There are no combinational input-to-output paths.
- Grant at edge T0: allow_jam is valid after T0 and grant_pulse is high for cycle T0..T1 only.
- Dwell: the state is READY after edge T0+MIN_GREEN-1. The earliest rotation executes at edge T0+MIN_GREEN, so allow_jam is stable for at least MIN_GREEN cycles.
- A pending rotation executes at the first edge where the state is READY, with no extra request needed.
- jam_start and jam_rotation on the same edge: start wins, and the rotation is dropped (not pended).
- Async reset mid-dwell: outputs clear immediately. The first grant after release requires a new jam_start or rotation.
- Index wrap: from current_road=NUM_ROADS-1 the search continues at 0.

## Configuration
- JAM_AUTO_ROTATE_EN defined:
  - In READY, if jam_sensor[current_road]=0, the block performs a rotation on that edge as if jam_rotation were asserted.
  - If no road is jammed, this ends in IDLE.
- Undefined: the grant is held indefinitely in READY until jam_start, jam_rotation, or disable.

## Test plan
- Reset / disable: hold rst_n=0, then deassert with jam_op_en=0 and sensors=4'b1111 -> allow_jam=0, current_road=0, busy=0 throughout.
- Fixed-priority start: sensors=4'b1010, pulse jam_start -> allow_jam=4'b0010, current_road=1, grant_pulse high one cycle, dwell_done high 7 cycles later (MIN_GREEN=8).
- Pended rotation with wrap: granted road 3, sensors=4'b1001, jam_rotation pulsed 2 cycles after grant -> allow_jam stays 4'b1000 for 8 cycles, then becomes 4'b0001 without a further request.
- Re-grant and release: granted road 2 in READY, sensors=4'b0100, rotate -> re-grant of road 2 with grant_pulse. Then sensors=0, rotate -> allow_jam=0, busy=0, current_road=2.
- Start vs. rotation collision: in READY on road 0, sensors=4'b0110, jam_start and jam_rotation on the same edge -> road 1 granted, no pending rotation, allow_jam held 8 cycles.
- JAM_AUTO_ROTATE_EN: granted road 0 in READY, sensors change 4'b0101 -> 4'b0100 -> allow_jam=4'b0100 on the next edge. Without the macro, allow_jam stays 4'b0001.
